// File: rtl/bus_arbiter_3to1_pkg.sv
// bus_arbiter_3to1_pkg
// Shared definitions for the 3:1 round-robin bus arbiter:
//   - arb_state_e : FSM state encoding (IDLE = no grant, GRANT = one owner)
//   - SEL_REQ0/1/2: select codes for the shared 3:1 data mux
//   - CNT_W       : width of the grant-tenure hold counter
//   - onehot_to_sel(): binary index of a one-hot grant vector
package bus_arbiter_3to1_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam logic [1:0] SEL_REQ0 = 2'b00;
  localparam logic [1:0] SEL_REQ1 = 2'b01;
  localparam logic [1:0] SEL_REQ2 = 2'b10;

  localparam int CNT_W = 8;

  // Never yields 2'b11; an all-zero vector maps to SEL_REQ0.
  function automatic logic [1:0] onehot_to_sel(input logic [2:0] oh);
    logic [1:0] sel;
    if (oh[1])      sel = SEL_REQ1;
    else if (oh[2]) sel = SEL_REQ2;
    else            sel = SEL_REQ0;
    return sel;
  endfunction

endpackage

// File: rtl/bus_arbiter_3to1_if.sv
// bus_arbiter_3to1_if
// Bundles the requester-side signals of the 3:1 arbiter.
//   req     : level request per requester, held until served
//   done    : 1-cycle tenure-end pulse per requester
//   grant   : registered one-hot grant
//   select  : registered mux select (binary index of grant)
//   busy    : any grant active
//   timeout : 1-cycle pulse when a grant is revoked by timeout
// Handshake: requester n raises req[n] and keeps it high until it sees
// grant[n]; the tenure ends on the clock edge where done[n] is high or
// req[n] is low (or on timeout). No other flow control exists.
// Modports: master = requester side, slave = arbiter side.
interface bus_arbiter_3to1_if;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] grant;
  logic [1:0] select;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done,
    input  grant, select, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, select, busy, timeout
  );
endinterface

// File: rtl/bus_arbiter_3to1_rr_pick3.sv
// rr_pick3
// Combinational round-robin winner selection for three requesters.
// The search starts at (last_owner+1) mod 3 and proceeds upward, so the
// previous owner is considered last.
//   req        : request mask
//   last_owner : index of the most recent grant (0..2)
//   winner     : one-hot winner, 000 when req is empty
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last_owner,
  output logic [2:0] winner
);

  always_comb begin
    winner = 3'b000;
    case (last_owner)
      2'd0: begin
        if (req[1])      winner = 3'b010;
        else if (req[2]) winner = 3'b100;
        else if (req[0]) winner = 3'b001;
      end
      2'd1: begin
        if (req[2])      winner = 3'b100;
        else if (req[0]) winner = 3'b001;
        else if (req[1]) winner = 3'b010;
      end
      default: begin
        if (req[0])      winner = 3'b001;
        else if (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/bus_arbiter_3to1.sv
// bus_arbiter_3to1
// Round-robin arbiter granting one of three requesters access to a shared
// 3:1 data mux. Two-state FSM (IDLE/GRANT) with registered outputs and
// zero-bubble hand-over between owners.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-low reset
//   req_i     : level requests
//   done_i    : 1-cycle tenure-end pulses (only the owner's bit matters)
//   grant_o   : registered one-hot grant
//   select_o  : registered mux select, holds its value while idle
//   busy_o    : |grant_o
//   timeout_o : 1-cycle pulse when a grant is revoked by timeout
//   state_o   : current FSM state (debug)
// Parameter MAX_HOLD (2..255): maximum tenure in cycles when ARB_TIMEOUT_EN
// is defined. Without ARB_TIMEOUT_EN there is no hold counter and
// timeout_o is tied low.
module bus_arbiter_3to1
  import bus_arbiter_3to1_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] req_i,
  input  logic [2:0] done_i,
  output logic [2:0] grant_o,
  output logic [1:0] select_o,
  output logic       busy_o,
  output logic       timeout_o,
  output arb_state_e state_o
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("bus_arbiter_3to1: MAX_HOLD must be in 2..255");
  end

  arb_state_e state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;

  logic [2:0] pick;
  logic [1:0] owner;
  logic       owner_done;
  logic       owner_abort;
  logic       tmo_hit;
  logic       release_now;
  logic       load_grant;

  rr_pick3 u_pick (
    .req        (req_i),
    .last_owner (last_q),
    .winner     (pick)
  );

  // In IDLE grant_q is zero so owner reads 0; every use is gated by GRANT.
  assign owner       = onehot_to_sel(grant_q);
  assign owner_done  = (state_q == GRANT) && done_i[owner];
  assign owner_abort = (state_q == GRANT) && !req_i[owner];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  // A release in the same cycle wins over the timeout: no pulse then.
  assign tmo_hit = (state_q == GRANT) && !(owner_done || owner_abort) &&
                   (cnt_q == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_hit;
      if (load_grant)              cnt_q <= '0;
      else if (state_q == GRANT)   cnt_q <= cnt_q + CNT_W'(1);
      else                         cnt_q <= '0;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign release_now = (state_q == GRANT) && (owner_done || owner_abort || tmo_hit);

  // The full request vector arbitrates on release: a still-requesting
  // owner sits last in the RR order, so it wins again only when alone.
  assign load_grant = (|req_i) && ((state_q == IDLE) || release_now);

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_i) state_d = GRANT;
      GRANT:   if (release_now) state_d = (|req_i) ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic (feeds the registered outputs)
  always_comb begin
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (load_grant) begin
      grant_d = pick;
      sel_d   = onehot_to_sel(pick);
      last_d  = onehot_to_sel(pick);
    end else if (release_now) begin
      grant_d = 3'b000;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      grant_q <= 3'b000;
      sel_q   <= SEL_REQ0;
      last_q  <= 2'd2;
    end else begin
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign grant_o  = grant_q;
  assign select_o = sel_q;
  assign busy_o   = |grant_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_bus_arbiter_3to1.sv
// tb_bus_arbiter_3to1
// Directed and randomized stimulus for bus_arbiter_3to1, checked every
// cycle against a behavioural round-robin model. Builds with or without
// ARB_TIMEOUT_EN (MAX_HOLD = 4 when the timeout is enabled).
module tb_bus_arbiter_3to1;
  import bus_arbiter_3to1_pkg::*;

`ifdef ARB_TIMEOUT_EN
  localparam int MH    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int MH    = 16;
  localparam bit TO_EN = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  bus_arbiter_3to1_if bus ();
  arb_state_e dbg_state;

  bus_arbiter_3to1 #(.MAX_HOLD(MH)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .req_i     (bus.req),
    .done_i    (bus.done),
    .grant_o   (bus.grant),
    .select_o  (bus.select),
    .busy_o    (bus.busy),
    .timeout_o (bus.timeout),
    .state_o   (dbg_state)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: owner index (-1 = none), last owner, cycles held.
  int m_owner;
  int m_last;
  int m_sel;
  int m_held;
  bit m_tmo;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 2;
    m_sel   = 0;
    m_held  = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic model_grant(input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (m_last + k) % 3;
      if (r[idx]) begin
        m_owner = idx;
        m_last  = idx;
        m_sel   = idx;
        m_held  = 0;
        break;
      end
    end
  endtask

  // One clock edge worth of the arbitration rules.
  task automatic model_update(input logic [2:0] r, input logic [2:0] d);
    bit rel;
    bit to;
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      if (r != 3'b000) model_grant(r);
    end else begin
      m_held++;
      rel = d[m_owner] || !r[m_owner];
      to  = TO_EN && !rel && (m_held == MH);
      if (rel || to) begin
        m_tmo = to;
        if (r != 3'b000) model_grant(r);
        else             m_owner = -1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [2:0] eg;
    eg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    check({tag, "_grant"},   8'(bus.grant),   8'(eg));
    check({tag, "_select"},  8'(bus.select),  8'(m_sel));
    check({tag, "_busy"},    8'(bus.busy),    8'(m_owner >= 0));
    check({tag, "_timeout"}, 8'(bus.timeout), 8'(m_tmo));
    check({tag, "_state"},   8'(dbg_state),   8'((m_owner >= 0) ? 1 : 0));
  endtask

  // Driver: apply inputs for one cycle, advance the model at the edge,
  // sample outputs on the falling edge.
  task automatic cycle(input logic [2:0] r, input logic [2:0] d, input string tag);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    model_update(r, d);
    @(negedge clk);
    bus.done = 3'b000;
    check_outputs(tag);
  endtask

  task automatic sync_reset();
    rst_i    = 1'b0;
    bus.req  = 3'b000;
    bus.done = 3'b000;
    model_reset();
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
  endtask

  initial begin
    logic [2:0] r;
    logic [2:0] d;

    rst_i    = 1'b0;
    bus.req  = 3'b000;
    bus.done = 3'b000;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_i = 1'b1;

    // Asynchronous reset mid-tenure with grant 010
    cycle(3'b010, 3'b000, "rst_setup");
    cycle(3'b010, 3'b000, "rst_hold");
    #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    bus.req = 3'b000;
    @(negedge clk);
    rst_i = 1'b1;

    // Single request and release to idle
    cycle(3'b000, 3'b000, "idle");
    cycle(3'b001, 3'b000, "single_grant");
    cycle(3'b001, 3'b000, "single_hold");
    cycle(3'b000, 3'b001, "single_release");
    cycle(3'b000, 3'b000, "single_idle");

    // Rotation with all three requesting
    sync_reset();
    cycle(3'b111, 3'b000, "rot_0");
    cycle(3'b111, 3'b001, "rot_1");
    cycle(3'b111, 3'b010, "rot_2");
    cycle(3'b111, 3'b100, "rot_3");
    cycle(3'b111, 3'b000, "rot_hold");

    // Abort by owner 1, non-owner done ignored
    cycle(3'b110, 3'b001, "abort_setup");
    cycle(3'b100, 3'b000, "abort");
    cycle(3'b101, 3'b001, "nonowner_done");
    cycle(3'b100, 3'b100, "done_with_req");
    cycle(3'b000, 3'b100, "abort_idle");

    // Long tenure: unbounded without the timeout, revoked every MH cycles with it
    sync_reset();
    for (int i = 0; i < 100; i++) cycle(3'b011, 3'b000, "hold");
    cycle(3'b000, 3'b000, "hold_release");

    // Simultaneous release and new request
    cycle(3'b001, 3'b000, "simul_setup");
    cycle(3'b100, 3'b001, "simul_release");
    cycle(3'b000, 3'b000, "simul_idle");

    // Randomized traffic
    r = 3'b000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      cycle(r, d, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
